// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 HI/LO multiply/divide unit for the EX stage, owning the HI/LO registers.
// Define MULDIV_DIV_EN to build the divide datapath; without it DIV/DIVU complete in one cycle as no-ops.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_MD_start,
  input  logic [1:0]       I_MD_op,
  input  logic [WIDTH-1:0] I_MD_rs_data,
  input  logic [WIDTH-1:0] I_MD_rt_data,
  input  logic             I_MD_mthi,
  input  logic             I_MD_mtlo,
  input  logic             I_MD_hilo_rd,
  output logic [WIDTH-1:0] O_MD_HI,
  output logic [WIDTH-1:0] O_MD_LO,
  output logic             O_MD_busy,
  output logic             O_MD_stall,
  output logic             O_MD_done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             op_div, neg_res, done;

  // Operand magnitudes; op[0]=0 selects the signed variants.
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign signed_op = ~I_MD_op[0];
  assign a_neg     = signed_op & I_MD_rs_data[WIDTH-1];
  assign b_neg     = signed_op & I_MD_rt_data[WIDTH-1];
  assign a_mag     = a_neg ? -I_MD_rs_data : I_MD_rs_data;
  assign b_mag     = b_neg ? -I_MD_rt_data : I_MD_rt_data;

  // Multiply: {acc_hi,acc_lo} holds partial product over the remaining multiplier bits.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;

`ifdef MULDIV_DIV_EN
  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic             neg_a, div_zero, div_ok;
  logic [WIDTH:0]   div_rem, div_diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign div_rem  = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, opnd};
  assign div_ok   = ~div_diff[WIDTH];
  // Divide by zero: remainder naturally ends as |dividend|, so the sign fixup restores it.
  assign quo_fix  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = neg_a ? -acc_hi : acc_hi;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      neg_a    <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == IDLE && I_MD_start) begin
      neg_a    <= a_neg;
      div_zero <= (I_MD_rt_data == '0);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opnd    <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (I_MD_start) begin
            op_div  <= I_MD_op[1];
            neg_res <= a_neg ^ b_neg;
            count   <= '0;
            acc_hi  <= '0;
            if (I_MD_op[1]) begin
`ifdef MULDIV_DIV_EN
              acc_lo <= a_mag;
              opnd   <= b_mag;
              state  <= RUN;
`else
              state  <= FIX;
`endif
            end else begin
              acc_lo <= b_mag;
              opnd   <= a_mag;
              state  <= RUN;
            end
          end else begin
            if (I_MD_mthi) hi <= I_MD_rs_data;
            if (I_MD_mtlo) lo <= I_MD_rs_data;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= FIX;
`ifdef MULDIV_DIV_EN
          if (op_div) begin
            acc_hi <= div_ok ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else
`endif
          begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          state <= IDLE;
          done  <= 1'b1;
          if (!op_div) {hi, lo} <= prod_fix;
`ifdef MULDIV_DIV_EN
          else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign O_MD_HI    = hi;
  assign O_MD_LO    = lo;
  assign O_MD_busy  = (state != IDLE);
  assign O_MD_done  = done;
  assign O_MD_stall = O_MD_busy & (I_MD_start | I_MD_mthi | I_MD_mtlo | I_MD_hilo_rd);
endmodule
